// File: rtl/led_status_driver.sv
// led_status_driver
//   Drives three board LEDs from per-channel modes. Each channel can be off,
//   on, blinking on a shared phase, or flashing on status events through a
//   retriggerable pulse stretcher with a forced dark gap. A shared PWM gate
//   applies global brightness. Outputs are registered.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   mode_i    per-channel mode, [1:0]=led1 [3:2]=led2 [5:4]=led3
//             (00 off, 01 on, 10 blink, 11 event flash)
//   evt_i     single-cycle event strobes, bit n = channel n
//   bright_i  global brightness, duty = (bright_i+1)/2^PWM_BITS
//   led1..3   LED drives, active high
module led_status_driver #(
    parameter int TICK_DIV   = 50000,
    parameter int STRETCH_MS = 50,
    parameter int BLINK_MS   = 500,
    parameter int PWM_BITS   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          mode_i,
    input  logic [2:0]          evt_i,
    input  logic [PWM_BITS-1:0] bright_i,
    output logic                led1,
    output logic                led2,
    output logic                led3
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STRETCH_MS + 1);
    localparam int BLK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_MS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [PRE_W-1:0]    pre_q;
    logic [BLK_W-1:0]    blk_q;
    logic                phase_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic                tick;
    logic                gate;

    state_t              state_q [3];
    state_t              state_d [3];
    logic [CNT_W-1:0]    cnt_q   [3];
    logic [CNT_W-1:0]    cnt_d   [3];
    logic [2:0]          pend_q, pend_d;
    logic [2:0]          raw;
    logic [2:0]          led_q;

    assign tick = (pre_q == PRE_MAX);
    assign gate = (pwm_q <= bright_i);

    // Shared time base, blink phase and PWM counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            pwm_q   <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (blk_q == BLK_MAX) begin
                    blk_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    blk_q <= blk_q + 1'b1;
                end
            end
            pwm_q <= pwm_q + 1'b1;
        end
    end

    // Channel FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                state_q[c] <= S_IDLE;
                cnt_q[c]   <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            pend_q <= pend_d;
        end
    end

    // Channel FSM next state. The phase transition fires on the tick that
    // takes the counter from 1 to 0, so a span lasts STRETCH_MS ticks
    // measured from the load, which bounds it to at most STRETCH_MS*TICK_DIV.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            pend_d[c]  = pend_q[c];
            if (mode_i[2*c +: 2] != 2'b11) begin
                state_d[c] = S_IDLE;
                cnt_d[c]   = '0;
                pend_d[c]  = 1'b0;
            end else begin
                case (state_q[c])
                    S_IDLE: begin
                        if (evt_i[c]) begin
                            state_d[c] = S_HOLD;
                            cnt_d[c]   = CNT_LOAD;
                        end
                    end
                    S_HOLD: begin
                        // Retrigger beats expiry
                        if (evt_i[c]) begin
                            cnt_d[c] = CNT_LOAD;
                        end else if (tick) begin
                            if (cnt_q[c] == CNT_ONE) begin
                                state_d[c] = S_GAP;
                                cnt_d[c]   = CNT_LOAD;
                            end else begin
                                cnt_d[c] = cnt_q[c] - 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick && (cnt_q[c] == CNT_ONE)) begin
                            // An event arriving on the expiry cycle still counts
                            if (pend_q[c] || evt_i[c]) begin
                                state_d[c] = S_HOLD;
                                cnt_d[c]   = CNT_LOAD;
                                pend_d[c]  = 1'b0;
                            end else begin
                                state_d[c] = S_IDLE;
                                cnt_d[c]   = '0;
                            end
                        end else begin
                            if (tick) begin
                                cnt_d[c] = cnt_q[c] - 1'b1;
                            end
                            if (evt_i[c]) begin
                                pend_d[c] = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                        pend_d[c]  = 1'b0;
                    end
                endcase
            end
        end
    end

    // Per-channel raw level
    always_comb begin
        raw = '0;
        for (int c = 0; c < 3; c++) begin
            case (mode_i[2*c +: 2])
                2'b00:   raw[c] = 1'b0;
                2'b01:   raw[c] = 1'b1;
                2'b10:   raw[c] = phase_q;
                default: raw[c] = (state_q[c] == S_HOLD);
            endcase
        end
    end

    // Registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= raw & {3{gate}};
        end
    end

    assign led1 = led_q[0];
    assign led2 = led_q[1];
    assign led3 = led_q[2];

endmodule
